muldiv_unit: RTL

//  Multi-cycle RV32M execute unit in the EX stage; responder side of the muldiv_start/muldiv_resp handshake

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: iterative shift-add multiplier and restoring divider.
// Holds its result in DONE until EX/MEM consumes it; start dropping mid-op aborts.
module muldiv_unit #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        muldiv_start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        ex_mem_load,
  output logic        muldiv_resp,
  output logic [31:0] muldiv_result,
  output logic        muldiv_busy
);

  localparam int unsigned N        = 32 / BITS_PER_CYCLE;
  localparam logic [4:0]  CNT_INIT = 5'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [2:0]  op_q,     op_d;
  logic        neg_q,    neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [63:0] acc_q,    acc_d;
  logic [31:0] b_q,      b_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [31:0] result_q, result_d;

  // Operand decode at accept time
  logic        is_div, a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] bypass_res;

  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = is_div ? ~funct3[0] : (funct3[1] == 1'b0);
    a_neg    = a_signed & rs1_data[31];
    b_neg    = b_signed & rs2_data[31];
    a_mag    = a_neg ? (~rs1_data + 32'd1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + 32'd1) : rs2_data;
    div_zero = is_div & (rs2_data == '0);
    div_ovf  = is_div & ~funct3[0] & (rs1_data == 32'h8000_0000) & (rs2_data == '1);
    if (div_zero) begin
      bypass_res = funct3[1] ? rs1_data : '1;
    end else begin
      bypass_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One compute cycle: acc holds {hi, lo} for multiply, {remainder, quotient/dividend} for divide
  logic [63:0] acc_step;
  logic [32:0] sum;
  logic        ge;

  always_comb begin
    acc_step = acc_q;
    sum      = '0;
    ge       = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!op_q[2]) begin
        sum      = {1'b0, acc_step[63:32]} + (acc_step[0] ? {1'b0, b_q} : 33'd0);
        acc_step = {sum, acc_step[31:1]};
      end else begin
        ge       = ({acc_step[63:32], acc_step[31]} >= {1'b0, b_q});
        acc_step = {(ge ? ({acc_step[62:32], acc_step[31]} - b_q)
                        : {acc_step[62:32], acc_step[31]}),
                    acc_step[30:0], ge};
      end
    end
  end

  // Sign fix-up and result selection
  logic [63:0] prod;
  logic [31:0] quo, rem, fix_res;

  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end else begin
      fix_res = op_q[1] ? rem : quo;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (muldiv_start) begin
          op_d      = funct3;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          acc_d     = {32'd0, a_mag};
          b_d       = b_mag;
          cnt_d     = CNT_INIT;
          if (div_zero || div_ovf) begin
            result_d = bypass_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!muldiv_start) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (!muldiv_start) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      default: begin
        if (!muldiv_start || ex_mem_load) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign muldiv_resp   = (state_q == S_DONE);
  assign muldiv_result = muldiv_resp ? result_q : '0;
  assign muldiv_busy   = (state_q == S_BUSY) || (state_q == S_FIX);

endmodule
